// File: rtl/sd_dat_transmitter.sv
// SD DAT0 block transmitter: start bit, FIFO words MSB-first, optional CRC16, end bit.
// Latency: START 3 cycles after Start_in; Done_out 1+DATA_WIDTH*BLOCK_WORDS(+16)+1 cycles later.
// Backpressure: waits in WAIT for a non-empty FIFO; an empty FIFO at prefetch aborts the block (Underrun_out).
// Optional CRC16 stage enabled by defining SD_DAT_CRC16_EN.
module sd_dat_transmitter #(
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = 128
) (
  input  logic                  RClk,
  input  logic                  Reset_n,
  input  logic                  Start_in,
  input  logic [DATA_WIDTH-1:0] Fifo_data_in,
  input  logic                  Fifo_empty_in,
  output logic                  Fifo_read_out,
  output logic                  Dat_out,
  output logic                  Dat_oe_out,
  output logic                  Busy_out,
  output logic                  Done_out,
  output logic                  Underrun_out
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int WCW = $clog2(BLOCK_WORDS + 1);

  localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_WIDTH - 1);
  localparam logic [BCW-1:0] BIT_PRE   = BCW'(DATA_WIDTH - 2);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(BLOCK_WORDS - 1);

  typedef enum logic [3:0] {
    IDLE, WAIT, FETCH, LOAD, START, DATA, CRC, STOP, END
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [WCW-1:0]        word_cnt_q, word_cnt_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                  miss_q, miss_d;
  logic                  underrun_q, underrun_d;

  logic last_word;
  logic bit_pre;
  logic bit_last;

  assign last_word = (word_cnt_q == WORD_LAST);
  assign bit_pre   = (bit_cnt_q == BIT_PRE);
  assign bit_last  = (bit_cnt_q == BIT_LAST);

`ifdef SD_DAT_CRC16_EN
  logic [15:0] crc_q, crc_d;
  logic [3:0]  crc_cnt_q, crc_cnt_d;
  logic        crc_fb;

  // Serial CRC16-CCITT feedback from the bit currently on the line.
  assign crc_fb = shift_q[DATA_WIDTH-1] ^ crc_q[15];

  // CRC accumulator and CRC bit counter.
  always_ff @(posedge RClk or negedge Reset_n) begin
    if (!Reset_n) begin
      crc_q     <= '0;
      crc_cnt_q <= '0;
    end else begin
      crc_q     <= crc_d;
      crc_cnt_q <= crc_cnt_d;
    end
  end
`endif

  // State register and datapath registers.
  always_ff @(posedge RClk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      word_cnt_q <= '0;
      bit_cnt_q  <= '0;
      miss_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      word_cnt_q <= word_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      miss_q     <= miss_d;
      underrun_q <= underrun_d;
    end
  end

  // Next-state, datapath updates and line outputs decoded from the current state.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    word_cnt_d    = word_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    miss_d        = miss_q;
    underrun_d    = 1'b0;
`ifdef SD_DAT_CRC16_EN
    crc_d         = crc_q;
    crc_cnt_d     = crc_cnt_q;
`endif
    Fifo_read_out = 1'b0;
    Dat_out       = 1'b1;
    Dat_oe_out    = 1'b0;
    Busy_out      = (state_q != IDLE);
    Done_out      = 1'b0;
    Underrun_out  = underrun_q;

    case (state_q)
      IDLE: begin
        if (Start_in) begin
          state_d    = Fifo_empty_in ? WAIT : FETCH;
          word_cnt_d = '0;
          bit_cnt_d  = '0;
          miss_d     = 1'b0;
`ifdef SD_DAT_CRC16_EN
          crc_d      = '0;
          crc_cnt_d  = '0;
`endif
        end
      end

      WAIT: begin
        if (!Fifo_empty_in) state_d = FETCH;
      end

      FETCH: begin
        Fifo_read_out = 1'b1;
        state_d       = LOAD;
      end

      LOAD: begin
        shift_d = Fifo_data_in;
        state_d = START;
      end

      START: begin
        Dat_oe_out = 1'b1;
        Dat_out    = 1'b0;
        state_d    = DATA;
      end

      DATA: begin
        Dat_oe_out = 1'b1;
        Dat_out    = shift_q[DATA_WIDTH-1];
        shift_d    = shift_q << 1;
        bit_cnt_d  = bit_cnt_q + BCW'(1);
`ifdef SD_DAT_CRC16_EN
        crc_d      = {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
`endif
        // Prefetch next word one bit early so it is ready right after bit 0.
        if (bit_pre && !last_word) begin
          if (!Fifo_empty_in) Fifo_read_out = 1'b1;
          else                miss_d        = 1'b1;
        end
        if (bit_last) begin
          bit_cnt_d = '0;
          if (last_word) begin
`ifdef SD_DAT_CRC16_EN
            state_d = CRC;
`else
            state_d = STOP;
`endif
          end else if (miss_q) begin
            state_d    = IDLE;
            underrun_d = 1'b1;
          end else begin
            shift_d    = Fifo_data_in;
            word_cnt_d = word_cnt_q + WCW'(1);
          end
        end
      end

`ifdef SD_DAT_CRC16_EN
      CRC: begin
        Dat_oe_out = 1'b1;
        Dat_out    = crc_q[15];
        crc_d      = {crc_q[14:0], 1'b0};
        crc_cnt_d  = crc_cnt_q + 4'd1;
        if (crc_cnt_q == 4'd15) state_d = STOP;
      end
`endif

      STOP: begin
        Dat_oe_out = 1'b1;
        Dat_out    = 1'b1;
        state_d    = END;
      end

      END: begin
        Done_out = 1'b1;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sd_dat_transmitter.sv
// Directed bench for sd_dat_transmitter: one 128-word instance and one 1-word instance.
// Cycle k is counted in negedges after Start_in was raised; outputs sampled at negedge.
// Expected values come from hand-derived cycle numbers and a reference CRC16 function.
module tb_sd_dat_transmitter;

  logic        clk;
  logic        rst_n;
  logic        start0, start1;
  logic [31:0] f0_dat, f1_dat;
  logic        f0_empty, f1_empty;
  logic        rd0, dat0, oe0, busy0, done0, und0;
  logic        rd1, dat1, oe1, busy1, done1, und1;

  int checks   = 0;
  int failures = 0;

`ifdef SD_DAT_CRC16_EN
  localparam int CL = 16;
  localparam int DONE_A = 4117;
`else
  localparam int CL = 0;
  localparam int DONE_A = 4101;
`endif
  localparam int STOP_A = DONE_A - 1;
  localparam int STOP_B = 36 + CL;
  localparam int DONE_B = STOP_B + 1;

  // FIFO model for the 128-word instance: data valid the cycle after a read.
  logic [31:0] mem0 [256];
  logic [7:0]  wp0, rp0;
  assign f0_empty = (wp0 == rp0);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rp0    <= 8'd0;
      f0_dat <= 32'd0;
    end else if (rd0) begin
      f0_dat <= mem0[rp0];
      rp0    <= rp0 + 8'd1;
    end
  end

  // FIFO model for the single-word instance.
  logic [31:0] wB = 32'hA5A5A5A5;
  logic [7:0]  f1_wr, f1_rd;
  assign f1_empty = (f1_wr == f1_rd);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f1_rd  <= 8'd0;
      f1_dat <= 32'd0;
    end else if (rd1) begin
      f1_dat <= wB;
      f1_rd  <= f1_rd + 8'd1;
    end
  end

  sd_dat_transmitter #(.DATA_WIDTH(32), .BLOCK_WORDS(128)) dut (
    .RClk(clk), .Reset_n(rst_n), .Start_in(start0), .Fifo_data_in(f0_dat),
    .Fifo_empty_in(f0_empty), .Fifo_read_out(rd0), .Dat_out(dat0), .Dat_oe_out(oe0),
    .Busy_out(busy0), .Done_out(done0), .Underrun_out(und0)
  );

  sd_dat_transmitter #(.DATA_WIDTH(32), .BLOCK_WORDS(1)) dut1 (
    .RClk(clk), .Reset_n(rst_n), .Start_in(start1), .Fifo_data_in(f1_dat),
    .Fifo_empty_in(f1_empty), .Fifo_read_out(rd1), .Dat_out(dat1), .Dat_oe_out(oe1),
    .Busy_out(busy1), .Done_out(done1), .Underrun_out(und1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc16_word(input logic [31:0] w);
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    for (int i = 31; i >= 0; i--) begin
      fb = w[i] ^ c[15];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  logic [31:0] cw [3];
  logic [15:0] crc_b;
  int nrd, ndone, nund, done_k, und_k, ones, bad, databad;
  logic        expb;
`ifdef SD_DAT_CRC16_EN
  logic [15:0] crc_obs;
`endif

  initial begin
    cw[0] = 32'h12345678; cw[1] = 32'h9ABCDEF0; cw[2] = 32'h0F0F0F0F;
    crc_b = crc16_word(wB);
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; wp0 = 8'd0; f1_wr = 8'd0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_read", 32'(rd0), 32'd0);
    check("rst_dat",  32'(dat0), 32'd1);
    check("rst_oe",   32'(oe0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done_und", 32'({done0, und0}), 32'd0);
    check("rst_dut1_dat_oe", 32'({oe1, dat1}), 32'h1);
    rst_n = 1'b1;
    @(negedge clk);

    // Full block of all-ones with a stray Start_in during DATA
    for (int i = 0; i < 128; i++) begin mem0[wp0] = 32'hFFFF_FFFF; wp0 = wp0 + 8'd1; end
    start0 = 1'b1;
    nrd = 0; ndone = 0; done_k = -1; ones = 0; bad = 0;
    for (int k = 1; k <= DONE_A + 3; k++) begin
      @(negedge clk);
      if (rd0) nrd++;
      if (done0) begin ndone++; if (done_k < 0) done_k = k; end
      if (k == 1) check("a_fetch_read", 32'(rd0), 32'd1);
      if (k == 2) check("a_load_no_read", 32'(rd0), 32'd0);
      if (k == 3) check("a_start_bit", 32'({oe0, dat0}), 32'h2);
      if (k >= 4 && k < 4100) begin
        if (oe0 && dat0) ones++;
      end
`ifdef SD_DAT_CRC16_EN
      if (k >= 4100 && k < 4116) begin
        crc_obs = {crc_obs[14:0], dat0};
        if (!oe0) bad++;
      end
`endif
      if (k == STOP_A) check("a_stop_bit", 32'({oe0, dat0}), 32'h3);
      if (k == DONE_A) check("a_end_oe_dat", 32'({oe0, dat0}), 32'h1);
      if (k == DONE_A + 1) check("a_idle_busy", 32'(busy0), 32'd0);
      if (k == 1 || k == 101) start0 = 1'b0;
      if (k == 100) start0 = 1'b1;
    end
    check("a_data_ones", 32'(ones), 32'd4096);
`ifdef SD_DAT_CRC16_EN
    check("a_crc_value", 32'(crc_obs), 32'h7FA1);
    check("a_crc_oe", 32'(bad), 32'd0);
`endif
    check("a_done_cycle", 32'(done_k), 32'(DONE_A));
    check("a_done_count", 32'(ndone), 32'd1);
    check("a_read_count", 32'(nrd), 32'd128);

    // Start with empty FIFO, 3 words arrive at cycle 20, then underrun
    start0 = 1'b1;
    nrd = 0; ndone = 0; nund = 0; und_k = -1; bad = 0; databad = 0;
    for (int k = 1; k <= 130; k++) begin
      @(negedge clk);
      if (rd0) nrd++;
      if (done0) ndone++;
      if (und0) begin nund++; if (und_k < 0) und_k = k; end
      if (k <= 20 && !(busy0 && !oe0 && dat0 && !rd0)) bad++;
      if (k == 21) check("c_fetch_read", 32'(rd0), 32'd1);
      if (k == 23) check("c_start_bit", 32'({oe0, dat0}), 32'h2);
      if (k >= 24 && k < 120) begin
        expb = cw[(k - 24) / 32][31 - ((k - 24) % 32)];
        if (!oe0 || dat0 !== expb) databad++;
      end
      if (k == 86)  check("c_prefetch_w3", 32'(rd0), 32'd1);
      if (k == 118) check("c_no_prefetch_empty", 32'(rd0), 32'd0);
      if (k == 120) check("c_underrun_outputs", 32'({und0, oe0, dat0, busy0}), 32'hA);
      if (k == 1) start0 = 1'b0;
      if (k == 20) begin
        for (int i = 0; i < 3; i++) begin mem0[wp0] = cw[i]; wp0 = wp0 + 8'd1; end
      end
    end
    check("c_wait_outputs", 32'(bad), 32'd0);
    check("c_data_bits", 32'(databad), 32'd0);
    check("c_underrun_cycle", 32'(und_k), 32'd120);
    check("c_underrun_count", 32'(nund), 32'd1);
    check("c_no_done", 32'(ndone), 32'd0);
    check("c_read_count", 32'(nrd), 32'd3);

    // Reset mid-DATA at word 5, bit 10
    for (int i = 0; i < 128; i++) begin mem0[wp0] = 32'h0000_0000; wp0 = wp0 + 8'd1; end
    start0 = 1'b1;
    for (int k = 1; k <= 185; k++) begin
      @(negedge clk);
      if (k == 1) start0 = 1'b0;
    end
    check("e_pre_reset_driving", 32'({oe0, dat0, busy0}), 32'h5);
    rst_n = 1'b0;
    #1;
    check("e_rst_read", 32'(rd0), 32'd0);
    check("e_rst_dat", 32'(dat0), 32'd1);
    check("e_rst_oe", 32'(oe0), 32'd0);
    check("e_rst_busy", 32'(busy0), 32'd0);
    check("e_rst_done_und", 32'({done0, und0}), 32'd0);
    wp0 = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (done0 || und0 || busy0 || rd0 || oe0) bad++;
    end
    check("e_quiet_after_reset", 32'(bad), 32'd0);

    // Single-word block 0xA5A5A5A5
    f1_wr = 8'd1;
    start1 = 1'b1;
    nrd = 0; done_k = -1; bad = 0;
    for (int k = 1; k <= DONE_B + 2; k++) begin
      @(negedge clk);
      if (rd1) nrd++;
      if (done1 && done_k < 0) done_k = k;
      if (k >= 3 && k <= STOP_B) begin
        if (k == 3)       expb = 1'b0;
        else if (k < 36)  expb = wB[35 - k];
        else if (k < STOP_B) expb = crc_b[51 - k];
        else              expb = 1'b1;
        if (!oe1 || dat1 !== expb) bad++;
      end
      if (k == DONE_B) check("b_end_oe_dat", 32'({oe1, dat1}), 32'h1);
      if (k == 1) start1 = 1'b0;
    end
    check("b_serial_sequence", 32'(bad), 32'd0);
    check("b_done_cycle", 32'(done_k), 32'(DONE_B));
    check("b_read_count", 32'(nrd), 32'd1);
    check("b_idle_busy", 32'(busy1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_dat_transmitter.md
SD_DAT_TRANSMITTER -- requirements
Module: sd_dat_transmitter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, FIFO word width in bits.
REQ-002 Parameter BLOCK_WORDS, default 128, words per SD data block (128 x 32 = 512 bytes).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports as listed in REQ-004 and REQ-005.
REQ-004 RClk  input  1  sole clock; all logic on posedge.
REQ-005 Reset_n  input  1  asynchronous active-low reset.
REQ-006 Start_in  input  1  single-cycle request to transmit one block.
REQ-007 Fifo_data_in  input  DATA_WIDTH  read data from FIFO; valid the cycle after a read strobe.
REQ-008 Fifo_empty_in  input  1  FIFO empty flag.
REQ-009 Fifo_read_out  output  1  FIFO read strobe, one cycle per word.
REQ-010 Dat_out  output  1  serial SD DAT0 line.
REQ-011 Dat_oe_out  output  1  DAT0 output enable.
REQ-012 Busy_out  output  1  high whenever state is not IDLE.
REQ-013 Done_out  output  1  one-cycle pulse after the end bit.
REQ-014 Underrun_out  output  1  one-cycle pulse on an aborted block.

Function
REQ-015 The state machine SHALL use states IDLE, WAIT, FETCH, LOAD, START, DATA, CRC, STOP and END.
REQ-016 In IDLE, Start_in SHALL go to FETCH if Fifo_empty_in=0, else to WAIT; Start_in SHALL be ignored in all other states.
REQ-017 WAIT SHALL hold, with Dat_oe_out=0, until Fifo_empty_in=0, then go to FETCH.
REQ-018 FETCH SHALL assert Fifo_read_out for exactly one cycle; LOAD SHALL capture Fifo_data_in into the shift register.
REQ-019 START SHALL drive Dat_out=0 for one cycle; Dat_oe_out SHALL be high from START through STOP inclusive.
REQ-020 DATA SHALL drive each word MSB first, one bit per cycle, for DATA_WIDTH*BLOCK_WORDS cycles total.
REQ-021 Prefetch: during the cycle a word's bit 1 is driven, and if words remain, Fifo_read_out SHALL pulse; at the end of the bit-0 cycle the shift register SHALL load Fifo_data_in, giving gapless transmission.
REQ-022 Underrun: if Fifo_empty_in=1 when a prefetch is due, there SHALL be no read; after the current word's bit 0, Dat_oe_out SHALL drop, Dat_out SHALL be 1, Underrun_out SHALL pulse, and the state SHALL return to IDLE with Done_out not asserted.
REQ-023 CRC16-CCITT (x^16+x^12+x^5+1, init 0x0000) SHALL be accumulated over all data bits; the CRC state SHALL drive 16 CRC bits MSB first.
REQ-024 STOP SHALL drive Dat_out=1 for one cycle; END SHALL pulse Done_out, drive Dat_oe_out=0 and return to IDLE.
REQ-025 Latency: with Start_in at cycle 0 and FIFO non-empty, FETCH SHALL occur at cycle 1, START at cycle 3 and Done_out at cycle 3+1+DATA_WIDTH*BLOCK_WORDS+16+1.
REQ-026 The word counter SHALL be wide enough for BLOCK_WORDS, the bit counter log2(DATA_WIDTH) bits, and the CRC counter 4 bits; the counters SHALL NOT wrap within a block.
REQ-027 Dat_out SHALL be 1 whenever Dat_oe_out=0.

Reset
REQ-028 Reset_n low SHALL asynchronously force IDLE, clear all counters, shift register and CRC, and set Fifo_read_out=0, Dat_out=1, Dat_oe_out=0, Busy_out=0, Done_out=0, Underrun_out=0.
REQ-029 Reset asserted mid-block SHALL abort immediately, with no Done_out or Underrun_out pulse after release.

Configuration
REQ-030 With macro SD_DAT_CRC16_EN defined, the CRC state and CRC logic SHALL be present as in REQ-023.
REQ-031 Without SD_DAT_CRC16_EN, DATA SHALL go directly to STOP, no CRC logic SHALL be synthesized, and the REQ-025 latency SHALL drop by 16 cycles.

Verification
REQ-032 Reset mid-DATA (word 5, bit 10) -> outputs match REQ-028 immediately; no pulses after release.
REQ-033 BLOCK_WORDS=128, FIFO preloaded with 128 x 0xFFFFFFFF, Start_in -> start bit 0, 4096 ones, CRC 0x7FA1, end bit 1, Done_out at cycle 4117, exactly 128 Fifo_read_out pulses.
REQ-034 BLOCK_WORDS=1, word 0xA5A5A5A5 -> Dat_out sequence 0,1010 0101 x4, CRC, 1, with no gap.
REQ-035 Start_in with FIFO empty; word written 20 cycles later -> WAIT with Dat_oe_out=0; START exactly 3 cycles after Fifo_empty_in falls.
REQ-036 FIFO holds 3 words, BLOCK_WORDS=128 -> Underrun_out pulses the cycle after word 3 bit 0, Dat_oe_out=0, no Done_out, IDLE.
REQ-037 Start_in repulsed during DATA -> ignored, no extra Fifo_read_out; with SD_DAT_CRC16_EN undefined, REQ-033 Done_out SHALL occur at cycle 4101.
